// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite ROM read path.
//   SPR_W / SPR_H / SPR_WORDS : sprite geometry (26x26, 676 words of 24-bit RGB)
//   KEY_COLOR                 : RGB value treated as transparent
//   dir_t                     : ROM bank select (four facings plus the closed-mouth bank)
//   fsm_state_t               : reader state, also the observable debug state
//   sanitize_dir()            : maps unsupported direction codes onto DIR_LEFT
package sprite_pkg;

  localparam int          SPR_W     = 26;
  localparam int          SPR_H     = 26;
  localparam int          SPR_WORDS = SPR_W * SPR_H;
  localparam logic [23:0] KEY_COLOR = 24'h000000;

  typedef enum logic [2:0] {
    DIR_LEFT  = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_FULL  = 3'd4
  } dir_t;

  typedef enum logic {
    ST_WAIT_FRAME = 1'b0,
    ST_ACTIVE     = 1'b1
  } fsm_state_t;

  // Codes 5-7 have no ROM bank behind them; fold them onto the left-facing bank.
  function automatic dir_t sanitize_dir(input logic [2:0] d);
    return (d <= 3'd4) ? dir_t'(d) : DIR_LEFT;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: combinational box test and ROM address generation.
//   DrawX, DrawY  : current pixel
//   sx, sy        : shadowed sprite top-left corner
//   pix_valid     : pixel lies in the visible region
//   in_box        : pixel falls inside the sprite rectangle
//   addr          : row-major ROM address (dy*SPR_W + dx)
//   addr_mirror   : horizontally mirrored address (dy*SPR_W + SPR_W-1-dx)
// Addresses are only meaningful while in_box is high.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int W = SPR_W,
  parameter int H = SPR_H
) (
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       pix_valid,
  output logic       in_box,
  output logic [9:0] addr,
  output logic [9:0] addr_mirror
);

  logic [10:0] x11, y11, sx11, sy11;
  logic [10:0] x_end, y_end;
  logic [10:0] dx, dy;
  logic [15:0] row_base;

  // Everything is widened to 11 bits so a sprite placed near the right or
  // bottom edge (or beyond 1023-W) clips instead of wrapping to column 0.
  assign x11   = {1'b0, DrawX};
  assign y11   = {1'b0, DrawY};
  assign sx11  = {1'b0, sx};
  assign sy11  = {1'b0, sy};
  assign x_end = sx11 + 11'(W);
  assign y_end = sy11 + 11'(H);
  assign dx    = x11 - sx11;
  assign dy    = y11 - sy11;

  assign in_box = pix_valid & (x11 >= sx11) & (x11 < x_end) &
                  (y11 >= sy11) & (y11 < y_end);

  assign row_base    = 16'(dy) * 16'(W);
  assign addr        = 10'(row_base + 16'(dx));
  assign addr_mirror = 10'(row_base + 16'(W - 1) - 16'(dx));

endmodule

// File: rtl/sprite_fetch_reader.sv
// sprite_fetch_reader: read-side initiator for one sprite ROM instance.
//   Clk, Reset            : pixel clock, synchronous active-high reset
//   frame_start           : vblank pulse; captures sprite_x/sprite_y/direction_in
//   pix_valid, DrawX/Y    : current visible pixel from the VGA controller
//   rom_addr(_mirror)     : registered read addresses to the ROM
//   rom_dir               : ROM bank select (DIR_FULL while the mouth is closed)
//   rom_data              : ROM word for the address presented in the previous cycle
//   pixel_out, pixel_hit  : pixel and opaque flag, two cycles after DrawX/DrawY
//   anim_frame            : 0 = mouth open, 1 = closed
// The registered rom_addr acts as the ROM's address register, so rom_data
// lines up with hit_d1 and the pixel leaves one register later.
// Handshake: none; one pixel per cycle, no back-pressure. pix_valid qualifies
// DrawX/DrawY, and pixel_hit qualifies pixel_out in the cycle it is high.
module sprite_fetch_reader
  import sprite_pkg::*;
#(
  parameter int          ANIM_DIV = 8,
  parameter logic [23:0] KEY      = KEY_COLOR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [2:0]  direction_in,
  output logic [9:0]  rom_addr,
  output logic [9:0]  rom_addr_mirror,
  output logic [2:0]  rom_dir,
  input  logic [23:0] rom_data,
  output logic [23:0] pixel_out,
  output logic        pixel_hit,
  output logic        anim_frame
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // Control state: FSM, shadows, animation. Debug-visible through state_q.
  fsm_state_t    state_q;
  logic [9:0]    sx_q, sy_q;
  dir_t          rom_dir_q;
  logic [CW-1:0] anim_cnt_q;
  logic          anim_q;
  dir_t          dir_new;
  logic          anim_wrap;

  assign dir_new   = sanitize_dir(direction_in);
  assign anim_wrap = (anim_cnt_q == CW'(ANIM_DIV - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_WAIT_FRAME;
      sx_q       <= '0;
      sy_q       <= '0;
      rom_dir_q  <= DIR_LEFT;
      anim_cnt_q <= '0;
      anim_q     <= 1'b0;
    end else if (frame_start) begin
      state_q <= ST_ACTIVE;
      sx_q    <= sprite_x;
      sy_q    <= sprite_y;
      // rom_dir follows the animation phase that becomes current this frame.
      if (anim_wrap) begin
        anim_cnt_q <= '0;
        anim_q     <= ~anim_q;
        rom_dir_q  <= anim_q ? dir_new : DIR_FULL;
      end else begin
        anim_cnt_q <= anim_cnt_q + CW'(1);
        rom_dir_q  <= anim_q ? DIR_FULL : dir_new;
      end
    end
  end

  // Stage 0: combinational box test against the shadowed position.
  logic       in_box;
  logic [9:0] addr_c, addr_mirror_c;

  sprite_addr_gen u_addr_gen (
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sx          (sx_q),
    .sy          (sy_q),
    .pix_valid   (pix_valid),
    .in_box      (in_box),
    .addr        (addr_c),
    .addr_mirror (addr_mirror_c)
  );

  // Stages 1 and 2.
  logic [9:0]  addr_d, addr_q, addr_mirror_d, addr_mirror_q;
  logic        hit_d1_d, hit_d1_q;
  logic [23:0] pixel_d, pixel_q;
  logic        pixel_hit_d, pixel_hit_q;
  logic        active;

  assign active = (state_q == ST_ACTIVE);

  always_comb begin
    // Outside the box the addresses hold, so the ROM sees no spurious reads.
    addr_d        = in_box ? addr_c : addr_q;
    addr_mirror_d = in_box ? addr_mirror_c : addr_mirror_q;
    hit_d1_d      = in_box & active;
    pixel_d       = rom_data;
    pixel_hit_d   = hit_d1_q & (rom_data != KEY) & active;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q        <= '0;
      addr_mirror_q <= '0;
      hit_d1_q      <= 1'b0;
      pixel_q       <= '0;
      pixel_hit_q   <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      addr_mirror_q <= addr_mirror_d;
      hit_d1_q      <= hit_d1_d;
      pixel_q       <= pixel_d;
      pixel_hit_q   <= pixel_hit_d;
    end
  end

  assign rom_addr        = addr_q;
  assign rom_addr_mirror = addr_mirror_q;
  assign rom_dir         = rom_dir_q;
  assign pixel_out       = pixel_q;
  assign pixel_hit       = pixel_hit_q;
  assign anim_frame      = anim_q;

endmodule

// File: tb/tb_sprite_fetch_reader.sv
module tb_sprite_fetch_reader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX, DrawY;
  logic [9:0]  sprite_x, sprite_y;
  logic [2:0]  direction_in;
  logic [9:0]  rom_addr, rom_addr_mirror;
  logic [2:0]  rom_dir;
  logic [23:0] rom_data;
  logic [23:0] pixel_out;
  logic        pixel_hit;
  logic        anim_frame;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  sprite_fetch_reader dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_start     (frame_start),
    .pix_valid       (pix_valid),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .sprite_x        (sprite_x),
    .sprite_y        (sprite_y),
    .direction_in    (direction_in),
    .rom_addr        (rom_addr),
    .rom_addr_mirror (rom_addr_mirror),
    .rom_dir         (rom_dir),
    .rom_data        (rom_data),
    .pixel_out       (pixel_out),
    .pixel_hit       (pixel_hit),
    .anim_frame      (anim_frame)
  );

  // ROM contents: addr 27 yellow, addr 28 transparent key, others 0x10_00xx.
  function automatic logic [23:0] rom_word(input logic [9:0] a);
    if (a == 10'd27) return 24'hFFFF00;
    if (a == 10'd28) return 24'h000000;
    return {8'h10, 6'h00, a};
  endfunction

  // The registered rom_addr is the ROM's address register; data follows it.
  assign rom_data = rom_word(rom_addr);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pix_valid = 1'b1;
    DrawX     = 10'(x);
    DrawY     = 10'(y);
    tick();
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic frame(input int x, input int y, input int d);
    sprite_x     = 10'(x);
    sprite_y     = 10'(y);
    direction_in = 3'(d);
    frame_start  = 1'b1;
    pix_valid    = 1'b0;
    tick();
    frame_start  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0; direction_in = '0;
    tick(); tick();
    check("rst_addr",   24'(rom_addr), 24'd0);
    check("rst_mirror", 24'(rom_addr_mirror), 24'd0);
    check("rst_dir",    24'(rom_dir), 24'd0);
    check("rst_pixout", pixel_out, 24'd0);
    check("rst_hit",    24'(pixel_hit), 24'd0);
    check("rst_anim",   24'(anim_frame), 24'd0);
    Reset = 1'b0;

    // Before the first frame_start: in box of the cleared shadow, but no hit.
    pix(5, 5);
    check("wait_addr", 24'(rom_addr), 24'd135);
    idle();
    check("wait_hit", 24'(pixel_hit), 24'd0);

    // Frame 1: sprite (100,50), facing left.
    frame(100, 50, 0);
    check("f1_dir", 24'(rom_dir), 24'd0);
    pix(100, 50);
    check("tl_addr",   24'(rom_addr), 24'd0);
    check("tl_mirror", 24'(rom_addr_mirror), 24'd25);
    idle();
    check("tl_hit", 24'(pixel_hit), 24'd1);
    check("tl_pix", pixel_out, 24'h100000);

    pix(125, 75);
    check("br_addr",   24'(rom_addr), 24'd675);
    check("br_mirror", 24'(rom_addr_mirror), 24'd650);
    idle();
    check("br_hit", 24'(pixel_hit), 24'd1);

    pix(126, 75); idle();
    check("right_miss", 24'(pixel_hit), 24'd0);
    check("hold_addr",  24'(rom_addr), 24'd675);
    pix(125, 76); idle();
    check("below_miss", 24'(pixel_hit), 24'd0);

    // Back-to-back: addr 27 opaque, addr 28 transparent key.
    pix(101, 51);
    pix(102, 51);
    check("op_hit", 24'(pixel_hit), 24'd1);
    check("op_pix", pixel_out, 24'hFFFF00);
    idle();
    check("key_hit", 24'(pixel_hit), 24'd0);
    check("key_pix", pixel_out, 24'h000000);

    // Mid-frame position change is not taken until frame_start.
    sprite_x = 10'd200;
    pix(100, 50); idle();
    check("shadow_old_hit", 24'(pixel_hit), 24'd1);
    frame(200, 50, 2);  // frame_start #2
    check("f2_dir", 24'(rom_dir), 24'd2);
    pix(100, 50); idle();
    check("shadow_old_miss", 24'(pixel_hit), 24'd0);
    pix(200, 50);
    check("shadow_new_addr", 24'(rom_addr), 24'd0);
    idle();
    check("shadow_new_hit", 24'(pixel_hit), 24'd1);

    // frame_start #3 coincident with a pixel; direction 7 folds to 0.
    sprite_x = 10'd300; direction_in = 3'd7; frame_start = 1'b1;
    pix(200, 50);
    frame_start = 1'b0;
    pix(200, 50);
    check("coinc_old_hit", 24'(pixel_hit), 24'd1);
    check("dir7_dir", 24'(rom_dir), 24'd0);
    idle();
    check("coinc_new_miss", 24'(pixel_hit), 24'd0);

    // Animation: frame_starts #4..#16 with direction right.
    for (int i = 4; i <= 7; i++) frame(300, 50, 2);
    check("anim7_frame", 24'(anim_frame), 24'd0);
    check("anim7_dir",   24'(rom_dir), 24'd2);
    frame(300, 50, 2);  // #8
    check("anim8_frame", 24'(anim_frame), 24'd1);
    check("anim8_dir",   24'(rom_dir), 24'd4);
    for (int i = 9; i <= 15; i++) frame(300, 50, 2);
    check("anim15_frame", 24'(anim_frame), 24'd1);
    frame(300, 50, 2);  // #16
    check("anim16_frame", 24'(anim_frame), 24'd0);
    check("anim16_dir",   24'(rom_dir), 24'd2);

    // Edge clip at (630,470).
    frame(630, 470, 2);  // #17
    pix(639, 479);
    check("clip_addr",   24'(rom_addr), 24'd243);
    check("clip_mirror", 24'(rom_addr_mirror), 24'd250);
    idle();
    check("clip_hit", 24'(pixel_hit), 24'd1);
    check("clip_pix", pixel_out, 24'h1000F3);

    // Sprite at column 1000 must not wrap onto the left edge.
    frame(1000, 0, 2);  // #18
    pix(0, 0); pix(1, 0);
    check("nowrap_hit0", 24'(pixel_hit), 24'd0);
    pix(639, 0);
    check("nowrap_hit1", 24'(pixel_hit), 24'd0);
    idle();
    check("nowrap_hit2", 24'(pixel_hit), 24'd0);

    // Reset during an active span.
    frame(100, 50, 0);  // #19
    pix(100, 50);
    Reset = 1'b1;
    pix(101, 50);
    Reset = 1'b0;
    check("mid_rst_hit",  24'(pixel_hit), 24'd0);
    check("mid_rst_anim", 24'(anim_frame), 24'd0);
    pix(5, 5); idle();
    check("post_rst_addr", 24'(rom_addr), 24'd135);
    check("post_rst_hit",  24'(pixel_hit), 24'd0);
    frame(0, 0, 1);
    check("post_rst_dir", 24'(rom_dir), 24'd1);
    pix(5, 5); idle();
    check("resume_hit", 24'(pixel_hit), 24'd1);
    check("resume_pix", pixel_out, 24'h100087);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_reader.md
Name: sprite_fetch_reader

Overview:
- Read-side initiator for the sprite ROM blocks (26x26 sprites, 676 words of 24-bit RGB, one-cycle registered read).
- Sits between the VGA controller (DrawX/DrawY) and one sprite ROM instance.
- Generates the normal and horizontally mirrored read addresses, the ROM direction select, and the mouth-animation frame.
- Realigns the returned ROM pixel with a hit/transparency flag for the colour mapper.

Parameters:
SPR_W, 26, sprite width in pixels
SPR_H, 26, sprite height in pixels
ANIM_DIV, 8, frames per mouth-animation phase (>=1)
KEY_COLOR, 24'h000000, transparent colour key

Ports:
Clk  in  1  system clock (pixel clock domain)
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pix_valid  in  1  DrawX/DrawY are in the visible region
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
sprite_x  in  10  requested top-left column
sprite_y  in  10  requested top-left row
direction_in  in  3  requested direction (0 left, 1 down, 2 right, 3 up)
rom_addr  out  10  read address to ROM
rom_addr_mirror  out  10  mirrored read address to ROM
rom_dir  out  3  ROM bank select (0-3 direction, 4 full/closed)
rom_data  in  24  ROM read data (valid 1 cycle after rom_addr)
pixel_out  out  24  sprite pixel aligned with pixel_hit
pixel_hit  out  1  pixel_out is an opaque sprite pixel
anim_frame  out  1  0 = mouth open, 1 = closed

Behaviour:
- Reset values:
  - rom_addr = 0, rom_addr_mirror = 0, rom_dir = 0.
  - pixel_out = 0, pixel_hit = 0, anim_frame = 0.
  - FSM = WAIT_FRAME; shadow registers cleared; anim counter = 0.
  - Pipeline valid bits cleared.
  - Reset mid-line discards all in-flight pixels.
- FSM:
  - WAIT_FRAME -> ACTIVE on the first frame_start.
  - In WAIT_FRAME, pixel_hit is forced to 0.
  - ACTIVE persists until Reset.
- Shadow registers:
  - sprite_x, sprite_y and direction_in are captured only on a frame_start cycle.
  - Changes between pulses have no effect, which prevents tearing.
  - direction_in values 5-7 are captured as 0.
- Animation:
  - A counter increments on each frame_start.
  - On reaching ANIM_DIV-1, the counter wraps to 0 and anim_frame toggles.
  - rom_dir = 4 when anim_frame = 1; otherwise the shadow direction.
  - rom_dir updates together with the shadows.
- Stage 0 (combinational):
  - dx = DrawX - sx, dy = DrawY - sy, computed in 11-bit unsigned arithmetic.
  - in_box = pix_valid & DrawX >= sx & DrawX < sx+SPR_W & DrawY >= sy & DrawY < sy+SPR_H.
  - Bounds are computed in 11 bits, so sprites near the 640/480 edges clip without wrap.
- Stage 1 (registered):
  - rom_addr = dy*SPR_W + dx.
  - rom_addr_mirror = dy*SPR_W + (SPR_W-1-dx).
  - hit_d1 = in_box & ACTIVE.
  - When in_box = 0, both addresses hold their previous values.
- Stage 2 (registered):
  - pixel_out = rom_data.
  - pixel_hit = hit_d1 & (rom_data != KEY_COLOR).
- Latency: pixel at DrawX/DrawY on cycle t -> pixel_out/pixel_hit on cycle t+2. Throughput is one pixel per cycle.
- frame_start coincident with pix_valid:
  - The current-cycle pixel uses the old shadows.
  - New shadows apply from t+1.
- Address ranges:
  - Maximum address is 675; no out-of-range address is ever issued while hit_d1 = 1.

Decomposition:
- Shared package sprite_pkg:
  - dir_t enum: DIR_LEFT=0, DIR_DOWN=1, DIR_RIGHT=2, DIR_UP=3, DIR_FULL=4.
  - SPR_W, SPR_H, SPR_WORDS=676, KEY_COLOR.
- One combinational sub-module, sprite_addr_gen:
  - Inputs: DrawX, DrawY, sx, sy, pix_valid.
  - Outputs: in_box, addr, addr_mirror.

Test Plan:
- Shadowed position, normal read:
  - Stimulus: shadow (100,50), dir 0; DrawX=100, DrawY=50.
  - Response at t+1: rom_addr=0, rom_addr_mirror=25.
  - Stimulus: DrawX=125, DrawY=75.
  - Response: rom_addr=675, rom_addr_mirror=650.
  - Stimulus: DrawX=126 or DrawY=76.
  - Response: pixel_hit=0 at t+2.
- Latency and transparency:
  - Stimulus: ROM model returns 24'hFFFF00 for address 27 and 24'h000000 for address 28.
  - Response: pixel_hit=1 with pixel_out=FFFF00 at t+2, then pixel_hit=0 on the next pixel.
- Shadowing:
  - Stimulus: change sprite_x 100->200 mid-frame without frame_start.
  - Response: DrawX=100 still hits.
  - Stimulus: after the next frame_start, DrawX=100.
  - Response: miss; DrawX=200 hits.
- Animation with ANIM_DIV=8, dir=2:
  - After 8 frame_starts: anim_frame=1, rom_dir=4.
  - After 16 frame_starts: anim_frame=0, rom_dir=2.
- Edge clip:
  - Stimulus: sprite (630,470), DrawX=639, DrawY=479.
  - Response: rom_addr = 9*26+9 = 243, hit.
  - Stimulus: sprite (1000,0).
  - Response: never hits.
- Reset:
  - Stimulus: Reset asserted during an active sprite span.
  - Response: pixel_hit=0 next cycle; it stays 0 until frame_start, even with in_box true.
